perf_counter_bank: RTL and testbench

Parametrised bank of performance-event counters for the core, succeeding the fixed seven-counter block. Each of NUM_EVT events supplies a multi-bit increment per cycle (multi-commit, multi-miss), counted into CNT_W-bit counters with global and per-counter enables, a hardware freeze input, sticky overflow flags with an interrupt, and a 32-bit CSR read/write port. Software reads wide counters through low/high halves; a low-half read snapshots the high half, so a two-read sequence is atomic.

---
 rtl/perf_counter_bank.sv | 161 ++++++++++++++++
 tb/tb_perf_counter_bank.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// Bank of NUM_EVT wide event counters with sticky overflow, interrupt and a 32-bit CSR port.
// Reads take 1 cycle. There is no backpressure: a read can be issued every cycle.
module perf_counter_bank #(
    parameter int NUM_EVT = 8,
    parameter int CNT_W   = 48,
    parameter int INC_W   = 2,
    parameter int ADDR_W  = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_EVT*INC_W-1:0] evt_inc,
    input  logic                     freeze,
    input  logic                     csr_re,
    input  logic                     csr_we,
    input  logic [ADDR_W-1:0]        csr_addr,
    input  logic [31:0]              csr_wdata,
    output logic [31:0]              csr_rdata,
    output logic                     csr_rvalid,
    output logic                     ovf_irq
);

    localparam int HI_W    = CNT_W - 32;
    localparam int CNT_END = 4 + 2 * NUM_EVT;

    logic [CNT_W-1:0]   cnt_q    [NUM_EVT];
    logic [CNT_W-1:0]   cnt_d    [NUM_EVT];
    logic [CNT_W:0]     inc_sum  [NUM_EVT];
    logic               gen_q, gen_d;
    logic [NUM_EVT-1:0] en_mask_q, en_mask_d;
    logic [NUM_EVT-1:0] ovf_q, ovf_d;
    logic [NUM_EVT-1:0] ovf_ie_q, ovf_ie_d;
    logic [HI_W-1:0]    shadow_q, shadow_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic               irq_q, irq_d;

    logic               is_ctrl, is_en, is_ovf, is_ie, is_cnt;
    logic [ADDR_W-1:0]  cnt_off;
    logic [ADDR_W-2:0]  cnt_idx;
    logic               cnt_is_hi;
    logic [CNT_W-1:0]   sel_cnt;
    logic [31:0]        rd_val;
    logic               clr;
    logic [NUM_EVT-1:0] wr_lo, wr_hi, cnt_en, ovf_set, w1c;
    logic               unused_wdata;

    assign unused_wdata = ^csr_wdata;

    // Address decode: counter words start at 4, LO on even offsets, HI on odd.
    always_comb begin
        is_ctrl   = (csr_addr == ADDR_W'(0));
        is_en     = (csr_addr == ADDR_W'(1));
        is_ovf    = (csr_addr == ADDR_W'(2));
        is_ie     = (csr_addr == ADDR_W'(3));
        is_cnt    = ({1'b0, csr_addr} >= (ADDR_W+1)'(4)) &&
                    ({1'b0, csr_addr} <  (ADDR_W+1)'(CNT_END));
        cnt_off   = csr_addr - ADDR_W'(4);
        cnt_idx   = cnt_off[ADDR_W-1:1];
        cnt_is_hi = cnt_off[0];
    end

    // Read path sees only pre-update state, so a same-cycle write is not visible.
    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < NUM_EVT; i++) begin
            if (cnt_idx == (ADDR_W-1)'(i)) begin
                sel_cnt = cnt_q[i];
            end
        end
        rd_val = '0;
        if (is_ctrl) begin
            rd_val = {31'b0, gen_q};
        end else if (is_en) begin
            rd_val = 32'(en_mask_q);
        end else if (is_ovf) begin
            rd_val = 32'(ovf_q);
        end else if (is_ie) begin
            rd_val = 32'(ovf_ie_q);
        end else if (is_cnt) begin
            rd_val = cnt_is_hi ? 32'(shadow_q) : sel_cnt[31:0];
        end
        shadow_d = shadow_q;
        if (csr_re && is_cnt && !cnt_is_hi) begin
            shadow_d = sel_cnt[CNT_W-1:32];
        end
        rvalid_d = csr_re;
        rdata_d  = csr_re ? rd_val : rdata_q;
    end

    always_comb begin
        gen_d     = gen_q;
        en_mask_d = en_mask_q;
        ovf_ie_d  = ovf_ie_q;
        w1c       = '0;
        clr       = 1'b0;
        if (csr_we) begin
            if (is_ctrl) begin
                gen_d = csr_wdata[0];
                clr   = csr_wdata[1];
            end
            if (is_en)  en_mask_d = csr_wdata[NUM_EVT-1:0];
            if (is_ovf) w1c       = csr_wdata[NUM_EVT-1:0];
            if (is_ie)  ovf_ie_d  = csr_wdata[NUM_EVT-1:0];
        end
    end

    // Priority per counter: clear, then CSR write, then increment.
    always_comb begin
        for (int i = 0; i < NUM_EVT; i++) begin
            wr_lo[i]   = csr_we && is_cnt && !cnt_is_hi && (cnt_idx == (ADDR_W-1)'(i));
            wr_hi[i]   = csr_we && is_cnt &&  cnt_is_hi && (cnt_idx == (ADDR_W-1)'(i));
            cnt_en[i]  = gen_q && en_mask_q[i] && !freeze;
            inc_sum[i] = {1'b0, cnt_q[i]} + (CNT_W+1)'(evt_inc[i*INC_W +: INC_W]);
            cnt_d[i]   = cnt_q[i];
            ovf_set[i] = 1'b0;
            if (clr) begin
                cnt_d[i] = '0;
            end else if (wr_lo[i]) begin
                cnt_d[i][31:0] = csr_wdata;
            end else if (wr_hi[i]) begin
                cnt_d[i][CNT_W-1:32] = csr_wdata[HI_W-1:0];
            end else if (cnt_en[i]) begin
                cnt_d[i]   = inc_sum[i][CNT_W-1:0];
                ovf_set[i] = inc_sum[i][CNT_W];
            end
        end
        ovf_d = (ovf_q & ~w1c) | ovf_set;
        irq_d = |(ovf_d & ovf_ie_d);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_EVT; i++) begin
                cnt_q[i] <= '0;
            end
            gen_q     <= 1'b1;
            en_mask_q <= '1;
            ovf_q     <= '0;
            ovf_ie_q  <= '0;
            shadow_q  <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            gen_q     <= gen_d;
            en_mask_q <= en_mask_d;
            ovf_q     <= ovf_d;
            ovf_ie_q  <= ovf_ie_d;
            shadow_q  <= shadow_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            irq_q     <= irq_d;
        end
    end

    assign csr_rdata  = rdata_q;
    assign csr_rvalid = rvalid_q;
    assign ovf_irq    = irq_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed and random stimulus for perf_counter_bank (4 events, 48-bit counters, 2-bit increments),
// checked against an arithmetic reference model.
module tb_perf_counter_bank;

    localparam longint unsigned WRAP  = 64'h1_0000_0000_0000;
    localparam longint unsigned TWO32 = 64'h1_0000_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  evt_inc;
    logic        freeze, csr_re, csr_we;
    logic [7:0]  csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_rvalid;
    logic        ovf_irq;

    int n_tests = 0;
    int n_fail  = 0;

    longint unsigned m_cnt [4];
    longint unsigned m_shadow;
    bit              m_gen;
    bit [3:0]        m_en, m_ovf, m_ie;
    bit              m_irq;
    logic [31:0]     last_rd;

    perf_counter_bank #(.NUM_EVT(4), .CNT_W(48), .INC_W(2), .ADDR_W(8)) dut (
        .clk(clk), .resetn(resetn), .evt_inc(evt_inc), .freeze(freeze),
        .csr_re(csr_re), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid), .ovf_irq(ovf_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_shadow = 0; m_gen = 1'b1; m_en = 4'hF; m_ovf = 4'h0; m_ie = 4'h0; m_irq = 1'b0;
    endtask

    // One clock cycle of stimulus; model advanced, DUT checked #1 after the edge.
    task automatic cycle(input logic [7:0] inc, input bit frz, input bit re, input bit we,
                         input int a, input logic [31:0] wd);
        longint unsigned exp_rd, new_shadow, s, inc_i;
        bit [3:0] set_b, w1c_b;
        bit clr;
        evt_inc = inc; freeze = frz; csr_re = re; csr_we = we;
        csr_addr = 8'(a); csr_wdata = wd;

        exp_rd = 0; new_shadow = m_shadow;
        if (a == 0) exp_rd = longint'(m_gen);
        else if (a == 1) exp_rd = longint'(m_en);
        else if (a == 2) exp_rd = longint'(m_ovf);
        else if (a == 3) exp_rd = longint'(m_ie);
        else if (a >= 4 && a < 12) begin
            if ((a - 4) % 2 == 0) begin
                exp_rd     = m_cnt[(a-4)/2] % TWO32;
                new_shadow = m_cnt[(a-4)/2] / TWO32;
            end else begin
                exp_rd = m_shadow;
            end
        end
        if (re) m_shadow = new_shadow;

        clr = we && (a == 0) && wd[1];
        set_b = 4'h0;
        for (int i = 0; i < 4; i++) begin
            inc_i = longint'((inc >> (2*i)) & 8'h3);
            if (clr) m_cnt[i] = 0;
            else if (we && a == 4 + 2*i)
                m_cnt[i] = (m_cnt[i] / TWO32) * TWO32 + longint'(wd);
            else if (we && a == 5 + 2*i)
                m_cnt[i] = longint'(wd & 32'hFFFF) * TWO32 + m_cnt[i] % TWO32;
            else if (m_gen && m_en[i] && !frz) begin
                s = m_cnt[i] + inc_i;
                if (s >= WRAP) begin
                    set_b[i] = 1'b1;
                    s = s - WRAP;
                end
                m_cnt[i] = s;
            end
        end
        w1c_b = 4'h0;
        if (we) begin
            if (a == 0) m_gen = wd[0];
            if (a == 1) m_en  = wd[3:0];
            if (a == 2) w1c_b = wd[3:0];
            if (a == 3) m_ie  = wd[3:0];
        end
        m_ovf = (m_ovf & ~w1c_b) | set_b;
        m_irq = |(m_ovf & m_ie);

        @(posedge clk);
        #1;
        chk("rvalid", csr_rvalid, re);
        if (re) chk($sformatf("rdata@%0d", a), csr_rdata, exp_rd);
        chk("irq", ovf_irq, m_irq);
        last_rd = csr_rdata;
        evt_inc = '0; freeze = 1'b0; csr_re = 1'b0; csr_we = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        cycle(8'h00, 1'b0, 1'b0, 1'b1, a, d);
    endtask

    task automatic rd(input int a);
        cycle(8'h00, 1'b0, 1'b1, 1'b0, a, 32'h0);
    endtask

    initial begin
        logic [31:0] wd;
        int a;
        resetn = 1'b0; evt_inc = '0; freeze = 1'b0; csr_re = 1'b0; csr_we = 1'b0;
        csr_addr = '0; csr_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        chk("rst_rvalid", csr_rvalid, 1'b0);
        chk("rst_rdata", csr_rdata, 32'h0);
        chk("rst_irq", ovf_irq, 1'b0);

        // Reset values
        rd(0); chk("rst_ctrl", last_rd, 32'h1);
        rd(1); chk("rst_en", last_rd, 32'hF);
        rd(2); chk("rst_ovf", last_rd, 32'h0);
        rd(3); chk("rst_ie", last_rd, 32'h0);
        rd(4); chk("rst_lo0", last_rd, 32'h0);
        rd(5); chk("rst_hi", last_rd, 32'h0);

        // Multi-increment, freeze, per-counter enable
        repeat (10) cycle(8'h13, 1'b0, 1'b0, 1'b0, 0, 0);
        rd(4); chk("cnt0_30", last_rd, 32'd30);
        rd(8); chk("cnt2_10", last_rd, 32'd10);
        repeat (5) cycle(8'h13, 1'b1, 1'b0, 1'b0, 0, 0);
        rd(4); chk("frz_cnt0", last_rd, 32'd30);
        rd(8); chk("frz_cnt2", last_rd, 32'd10);
        wr(1, 32'hE);
        repeat (4) cycle(8'h13, 1'b0, 1'b0, 1'b0, 0, 0);
        rd(4); chk("mask_cnt0", last_rd, 32'd30);
        rd(8); chk("mask_cnt2", last_rd, 32'd14);

        // Atomic wide read through the shadow
        wr(7, 32'h1234); wr(6, 32'hFFFF_FFFF);
        cycle(8'h04, 1'b0, 1'b0, 1'b0, 0, 0);
        rd(6); chk("wide_lo", last_rd, 32'h0);
        rd(7); chk("wide_hi", last_rd, 32'h1235);
        wr(6, 32'hFFFF_FFFF);
        cycle(8'h04, 1'b0, 1'b1, 1'b0, 6, 0); chk("snap_lo", last_rd, 32'hFFFF_FFFF);
        repeat (3) cycle(8'h04, 1'b0, 1'b0, 1'b0, 0, 0);
        rd(7); chk("snap_hi", last_rd, 32'h1235);
        rd(6); chk("snap_lo2", last_rd, 32'h3);
        rd(7); chk("snap_hi2", last_rd, 32'h1236);

        // Overflow and interrupt
        wr(3, 32'h8); wr(11, 32'hFFFF); wr(10, 32'hFFFF_FFFE);
        cycle(8'hC0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("ovf_irq_rise", ovf_irq, 1'b1);
        rd(10); chk("wrap_lo3", last_rd, 32'h1);
        rd(2);  chk("ovf_set", last_rd, 32'h8);
        wr(11, 32'hFFFF); wr(10, 32'hFFFF_FFFF);
        cycle(8'h40, 1'b0, 1'b0, 1'b1, 2, 32'h8);
        rd(2); chk("ovf_set_beats_w1c", last_rd, 32'h8);
        wr(2, 32'h8); chk("irq_fall", ovf_irq, 1'b0);
        rd(2); chk("ovf_cleared", last_rd, 32'h0);

        // Same-cycle conflicts
        wr(1, 32'hF);
        cycle(8'h03, 1'b0, 1'b0, 1'b1, 4, 32'h100);
        rd(4); chk("wr_beats_inc", last_rd, 32'h100);
        wr(11, 32'hFFFF); wr(10, 32'hFFFF_FFFF);
        cycle(8'h40, 1'b0, 1'b0, 1'b0, 0, 0);
        cycle(8'hAA, 1'b0, 1'b0, 1'b1, 0, 32'h3);
        for (int i = 0; i < 4; i++) begin
            rd(4 + 2*i); chk($sformatf("clr_lo%0d", i), last_rd, 32'h0);
            rd(5 + 2*i); chk($sformatf("clr_hi%0d", i), last_rd, 32'h0);
        end
        rd(2); chk("clr_keeps_ovf", last_rd, 32'h8);
        cycle(8'h00, 1'b0, 1'b1, 1'b1, 1, 32'h5); chk("rw_old_val", last_rd, 32'hF);
        rd(1); chk("rw_new_val", last_rd, 32'h5);

        // Randomized traffic against the model
        wr(3, 32'hF); wr(1, 32'hF);
        for (int n = 0; n < 400; n++) begin
            a = int'($urandom_range(0, 15));
            wd = $urandom;
            if (a >= 4 && a < 12 && (a % 2 == 1) && $urandom_range(0, 1) == 1) wd = 32'hFFFF;
            if (a >= 4 && a < 12 && (a % 2 == 0) && $urandom_range(0, 1) == 1)
                wd = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            if (a == 0) wd = ($urandom_range(0, 7) == 0) ? 32'h3 : (($urandom_range(0, 5) == 0) ? 32'h0 : 32'h1);
            cycle(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0, a, wd);
        end

        // Asynchronous reset in mid-cycle
        wr(0, 32'h1); wr(1, 32'hF); wr(3, 32'hF); wr(4, 32'h5);
        wr(9, 32'hFFFF); wr(8, 32'hFFFF_FFFF);
        cycle(8'h10, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("pre_rst_irq", ovf_irq, 1'b1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_irq", ovf_irq, 1'b0);
        chk("arst_ovf", dut.ovf_q, 4'h0);
        chk("arst_rvalid", csr_rvalid, 1'b0);
        for (int i = 0; i < 4; i++) chk($sformatf("arst_cnt%0d", i), dut.cnt_q[i], 48'h0);
        model_reset();
        csr_re = 1'b1; csr_addr = 8'h0;
        @(posedge clk);
        #1;
        chk("rst_edge_no_rvalid", csr_rvalid, 1'b0);
        csr_re = 1'b0;
        resetn = 1'b1;
        rd(4); chk("post_rst_lo0", last_rd, 32'h0);
        rd(8); chk("post_rst_lo2", last_rd, 32'h0);
        rd(2); chk("post_rst_ovf", last_rd, 32'h0);
        rd(0); chk("post_rst_ctrl", last_rd, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
